// File: rtl/ram_wide_seq_pkg.sv
// Shared types for the ram_wide capture/readout sequencer.
package ram_wide_seq_pkg;

  // Sequencer states. IDLE must stay the all-zero encoding so that
  // a freshly reset block reads as idle on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_SEND    = 3'd4
  } seq_state_e;

  // Width of an index that counts 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_wide_unpacker.sv
// Holds one wide RAM word and walks it channel by channel.
// load_i captures a new word and restarts at channel 0; advance_i steps to
// the next channel, wrapping after the last one.
module ram_wide_unpacker
  import ram_wide_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] word_i,
  input  logic                               advance_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic                               last_ch_o
);

  localparam int TOTAL_WIDTH = NUM_CHANNELS * DATA_WIDTH;
  localparam int CH_W        = idx_width(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  logic [TOTAL_WIDTH-1:0] word_q, word_d;
  logic [CH_W-1:0]        ch_idx_q, ch_idx_d;

  // Next word/channel: load has priority over advance.
  always_comb begin
    word_d   = word_q;
    ch_idx_d = ch_idx_q;
    if (load_i) begin
      word_d   = word_i;
      ch_idx_d = '0;
    end else if (advance_i) begin
      ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + CH_W'(1);
    end
  end

  // Word and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      ch_idx_q <= '0;
    end else begin
      word_q   <= word_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  assign data_o    = word_q[int'(ch_idx_q) * DATA_WIDTH +: DATA_WIDTH];
  assign last_ch_o = (ch_idx_q == LAST_CH);

endmodule

// File: rtl/ram_wide_seq.sv
// Capture/readout sequencer for the ram_wide sample store.
// CAPTURE writes each valid packed sample to the next RAM address; a dump
// reads every stored word back and streams it out one channel per beat.
//
// Output stream handshake: a beat transfers on a cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data and out_last hold their values and out_valid stays high.
module ram_wide_seq
  import ram_wide_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_in,
  input  logic                               sample_valid,
  input  logic                               arm,
  input  logic                               stop,
  input  logic                               dump_req,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overflow,
  output logic [ADDR_WIDTH:0]                sample_count,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ram_wdata,
  output logic                               ram_write_en,
  output logic                               ram_read_en,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ram_rdata,
  input  logic                               ram_full,
  output seq_state_e                         dbg_state
);

  localparam int TOTAL_WIDTH = NUM_CHANNELS * DATA_WIDTH;
  localparam int PW          = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  seq_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          unp_load;
  logic          unp_advance;
  logic          last_ch;
  logic          last_word;
  logic          room;

  // Pointers are one bit wider than the RAM address so that "full" (DEPTH)
  // is representable and never aliases back onto address 0.
  assign room      = (wr_ptr_q < DEPTH_P) && !ram_full;
  assign last_word = (rd_ptr_q == count_q - ONE_P);

  // Next-state, pointer updates and RAM/stream strobes.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    ram_wdata    = '0;
    ram_addr     = rd_ptr_q[ADDR_WIDTH-1:0];
    unp_load     = 1'b0;
    unp_advance  = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          wr_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ST_CAPTURE;
        end else if (dump_req && (count_q != '0)) begin
          rd_ptr_d = '0;
          state_d  = ST_RD;
        end
      end

      ST_CAPTURE: begin
        ram_addr     = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_wdata    = sample_in;
        ram_write_en = sample_valid && room;
        if (ram_write_en) begin
          wr_ptr_d = wr_ptr_q + ONE_P;
          count_d  = count_q + ONE_P;
        end else if (sample_valid) begin
          overflow_d = 1'b1;
        end
        // A sample arriving with stop is still written above.
        if (stop) begin
          state_d = ST_IDLE;
        end
      end

      ST_RD: begin
        ram_read_en = 1'b1;
        state_d     = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // ram_rdata is valid during this cycle; latch it at the closing edge.
        unp_load = 1'b1;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = last_ch && last_word;
        if (out_ready) begin
          unp_advance = 1'b1;
          if (last_ch) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
            state_d  = last_word ? ST_IDLE : ST_RD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointers, stored count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  ram_wide_unpacker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load_i    (unp_load),
    .word_i    (ram_rdata),
    .advance_i (unp_advance),
    .data_o    (out_data),
    .last_ch_o (last_ch)
  );

  assign busy         = (state_q != ST_IDLE);
  assign overflow     = overflow_q;
  assign sample_count = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_wide_seq.sv
// Bench for ram_wide_seq with a behavioural ram_wide beside it.
module tb_ram_wide_seq;
  import ram_wide_seq_pkg::*;

  localparam int NC    = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TW    = NC * DW;

  logic            clk;
  logic            rst;
  logic [TW-1:0]   sample_in;
  logic            sample_valid;
  logic            arm;
  logic            stop;
  logic            dump_req;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            overflow;
  logic [AW:0]     sample_count;
  logic [TW-1:0]   ram_wdata;
  logic            ram_write_en;
  logic            ram_read_en;
  logic [AW-1:0]   ram_addr;
  logic [TW-1:0]   ram_rdata;
  logic            ram_full;
  seq_state_e      dbg_state;

  ram_wide_seq #(
    .NUM_CHANNELS (NC),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .stop         (stop),
    .dump_req     (dump_req),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
    .sample_count (sample_count),
    .ram_wdata    (ram_wdata),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .ram_full     (ram_full),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ram_wide: registered read, data one cycle after read_en.
  logic [TW-1:0] ram_mem [DEPTH];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read_en)  ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- reference model ----------------
  logic [TW-1:0] model_words [DEPTH];
  int            model_count;
  bit            model_ovf;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;
  int            beats_seen;
  bit            mon_en;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  bit            prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: every accepted beat is popped from the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) check("hold_data", out_data, prev_data);
      if (prev_last)  check("busy_fall", busy, 1'b0);
      prev_last = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e);
          check("beat_last", out_last, exp_q.size() == 0);
          prev_last = (exp_q.size() == 0);
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    stop         = 1'b0;
    dump_req     = 1'b0;
    out_ready    = 1'b0;
    ram_full     = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    model_count = 0;
    model_ovf   = 1'b0;
  endtask

  // Arm, present n samples (ram_full raised on sample full_at), then stop.
  task automatic capture(input int n, input bit rand_data, input int full_at, input bit stop_with_last);
    int wr;
    @(posedge clk); #1;
    arm = 1'b1;
    wr = 0;
    model_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [TW-1:0] v;
      bit            exp_we;
      @(posedge clk); #1;
      arm = 1'b0;
      if (rand_data) v = {$urandom, $urandom};
      else           v = {NC{DW'(i + 1)}};
      sample_in    = v;
      sample_valid = 1'b1;
      ram_full     = (i == full_at);
      stop         = stop_with_last && (i == n - 1);
      @(negedge clk);
      exp_we = (wr < DEPTH) && (i != full_at);
      check("cap_we", ram_write_en, exp_we);
      if (exp_we) begin
        check("cap_addr", ram_addr, wr);
        check("cap_wdata", ram_wdata, v);
        model_words[wr] = v;
        wr++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    model_count = wr;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    ram_full     = 1'b0;
    if (!stop_with_last) begin
      stop     = 1'b1;
      dump_req = 1'b1;
      @(posedge clk); #1;
    end
    stop     = 1'b0;
    dump_req = 1'b0;
    @(negedge clk);
    check("cap_busy", busy, 1'b0);
    check("cap_rd_en", ram_read_en, 1'b0);
    check("cap_count", sample_count, model_count);
    check("cap_ovf", overflow, model_ovf);
  endtask

  // Dump everything; mode 0 ready high, 1 toggling, 2 random.
  task automatic dump(input int mode, output int busy_cycles);
    int i;
    exp_q.delete();
    for (int w = 0; w < model_count; w++)
      for (int c = 0; c < NC; c++)
        exp_q.push_back(model_words[w][c*DW +: DW]);
    beats_seen  = 0;
    busy_cycles = 0;
    mon_en      = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b1;
    i = 0;
    forever begin
      @(posedge clk); #1;
      dump_req = 1'b0;
      if (!busy) break;
      busy_cycles++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = i[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      i++;
      if (i > 2000) begin
        check("dump_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(negedge clk);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    check("dump_drain", exp_q.size(), 0);
    check("dump_beats", beats_seen, model_count * NC);
    check("dump_count_kept", sample_count, model_count);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc;
    logic [TW-1:0] w3;
    n_checks   = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    beats_seen = 0;

    // 1. reset values
    do_reset(2);
    @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", sample_count, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_we", ram_write_en, 0);
    check("rst_re", ram_read_en, 0);
    check("rst_addr", ram_addr, 0);

    // 2. nine patterned samples, full-rate dump
    capture(9, 1'b0, -1, 1'b0);
    dump(0, bc);
    check("throughput", bc, 9 * (NC + 2));

    // 3. overfill: 20 samples into 16 words
    capture(20, 1'b1, -1, 1'b0);
    check("ovf_count16", sample_count, DEPTH);
    check("ovf_flag", overflow, 1'b1);

    // 4. stalled and random-ready dumps, repeated (non-destructive)
    dump(1, bc);
    dump(2, bc);

    // arm clears overflow; stop coincides with a written sample
    capture(5, 1'b1, -1, 1'b1);

    // 6. reset while presenting word 3, channel 2
    exp_q.delete();
    for (int w = 0; w < model_count; w++)
      for (int c = 0; c < NC; c++)
        exp_q.push_back(model_words[w][c*DW +: DW]);
    w3 = model_words[3];
    beats_seen = 0;
    mon_en     = 1'b1;
    @(posedge clk); #1;
    dump_req  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      dump_req = 1'b0;
      if (beats_seen == 3 * NC + 2) break;
    end
    mon_en = 1'b0;
    check("mid_reached", beats_seen, 3 * NC + 2);
    check("mid_valid", out_valid, 1'b1);
    check("mid_data", out_data, w3[2*DW +: DW]);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_count = 0;
    model_ovf   = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_count", sample_count, 0);
    check("abort_last", out_last, 0);

    // 5. empty dump ignored, then arm wins over dump_req
    @(posedge clk); #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("empty_dump_busy", busy, 0);
    check("empty_dump_re", ram_read_en, 0);
    @(posedge clk); #1;
    arm      = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    arm      = 1'b0;
    dump_req = 1'b0;
    check("arm_wins_state", dbg_state, ST_CAPTURE);
    check("arm_wins_busy", busy, 1'b1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("arm_stop_busy", busy, 0);
    check("arm_stop_count", sample_count, 0);

    // ram_full back-pressure drops one sample and sets overflow
    capture(7, 1'b1, 2, 1'b1);
    dump(2, bc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
